// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control definitions: RV32I opcodes, ALU codes seen by the one-hot decoder,
// and the entry held in each stage register.
package alu_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1101;

  typedef struct packed {
    logic [3:0] code;
    logic       illegal;
  } entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational map of (opcode, funct3, funct7) to an ALU code plus illegal flag.
// Illegal encodings always leave with code ADD so nothing outside the ten codes escapes.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output entry_t     o_entry
);

  logic       w_alt;
  logic       w_base;
  logic [3:0] w_code;
  logic       w_ill;

  assign w_alt  = (i_funct7 == F7_ALT);
  assign w_base = (i_funct7 == F7_BASE);

  always_comb begin
    w_code = ALU_ADD;
    w_ill  = 1'b0;
    case (i_opcode)
      OP_R, OP_I: begin
        case (i_funct3)
          3'b000: w_code = (i_opcode == OP_R && w_alt) ? ALU_SUB : ALU_ADD;
          3'b001: w_code = ALU_SLL;
          3'b010: w_code = ALU_SLT;
          3'b011: w_code = ALU_SLTU;
          3'b100: w_code = ALU_XOR;
          3'b101: w_code = w_alt ? ALU_SRA : ALU_SRL;
          3'b110: w_code = ALU_OR;
          default: w_code = ALU_AND;
        endcase
        // R-type checks funct7 everywhere; I-type only where it encodes the shift kind
        if (i_opcode == OP_R)
          w_ill = !(w_base || (w_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101)));
        else if (i_funct3 == 3'b001)
          w_ill = !w_base;
        else if (i_funct3 == 3'b101)
          w_ill = !(w_base || w_alt);
      end
      OP_BR: begin
        case (i_funct3[2:1])
          2'b00:   w_code = ALU_SUB;
          2'b10:   w_code = ALU_SLT;
          2'b11:   w_code = ALU_SLTU;
          default: w_ill  = 1'b1;
        endcase
      end
      OP_LD, OP_ST, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_code = ALU_ADD;
      default: w_ill = 1'b1;
    endcase
  end

  assign o_entry.code    = w_ill ? ALU_ADD : w_code;
  assign o_entry.illegal = w_ill;

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decode into a two-entry skid buffer, 1-cycle latency,
// in_ready comes straight from the skid-occupancy register; flush/rst empty both entries.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control_signal,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           w_dec;
  logic             w_acc;
  logic             w_drain;
  entry_t           r_main;
  entry_t           r_skid;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic [CNT_W-1:0] r_cnt;

  alu_ctrl_decode u_decode (
    .i_opcode (opcode),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .o_entry  (w_dec)
  );

  assign in_ready = ~r_skid_vld;
  assign w_acc    = in_valid & in_ready & ~flush;
  assign w_drain  = r_main_vld & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (r_skid_vld) begin
      // in_ready is low here, so the only possible event is a drain
      if (w_drain) begin
        r_main     <= r_skid;
        r_skid_vld <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_main_vld || out_ready) begin
        r_main     <= w_dec;
        r_main_vld <= 1'b1;
      end else begin
        r_skid     <= w_dec;
        r_skid_vld <= 1'b1;
      end
    end else if (w_drain) begin
      r_main_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_acc && w_dec.illegal && r_cnt != CNT_MAX)
      r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid          = r_main_vld;
  assign alu_control_signal = r_main.code;
  assign illegal            = r_main.illegal;
  assign illegal_count      = r_cnt;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: fixed vector table, directed corner sequences and a random
// stream against a queue-based model; a CNT_W=2 copy shares the inputs for saturation.
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic       in_ready, out_valid, illegal;
  logic [3:0] alu_control_signal;
  logic [7:0] illegal_count;
  logic       s_in_ready, s_out_valid, s_illegal;
  logic [3:0] s_code;
  logic [1:0] s_count;

  alu_ctrl_stage #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .alu_control_signal(alu_control_signal), .illegal(illegal),
    .illegal_count(illegal_count)
  );

  alu_ctrl_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(s_out_valid),
    .out_ready(out_ready), .alu_control_signal(s_code), .illegal(s_illegal),
    .illegal_count(s_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  // funct3 -> base operation code; the alternate funct7 selects the neighbouring code
  localparam logic [3:0] BASE_CODE [8] = '{4'd0, 4'd5, 4'd8, 4'd13, 4'd4, 4'd6, 4'd3, 4'd2};

  exp_t q[$];
  int   m_cnt;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    exp_t e;
    bit   alt  = (f7 == 7'h20);
    bit   zero = (f7 == 7'h00);
    e.code = 4'd0;
    e.ill  = 1'b0;
    if (op == 7'h33) begin
      if (zero || (alt && (f3 == 3'd0 || f3 == 3'd5))) e.code = BASE_CODE[f3] + (alt ? 4'd1 : 4'd0);
      else e.ill = 1'b1;
    end else if (op == 7'h13) begin
      if (f3 == 3'd1 && !zero) e.ill = 1'b1;
      else if (f3 == 3'd5 && !(zero || alt)) e.ill = 1'b1;
      else if (f3 == 3'd5) e.code = alt ? 4'd7 : 4'd6;
      else e.code = BASE_CODE[f3];
    end else if (op == 7'h63) begin
      if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
      else if (f3 < 3'd2) e.code = 4'd1;
      else if (f3 < 3'd6) e.code = 4'd8;
      else e.code = 4'd13;
    end else if (op == 7'h03 || op == 7'h23 || op == 7'h6f || op == 7'h67 ||
                 op == 7'h37 || op == 7'h17) begin
      e.code = 4'd0;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int c = (m_cnt > 255) ? 255 : m_cnt;
    int s = (m_cnt > 3) ? 3 : m_cnt;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("code", 32'(alu_control_signal), 32'(q[0].code));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
    chk("count", 32'(illegal_count), 32'(c));
    chk("sat_count", 32'(s_count), 32'(s));
    chk("sat_valid", 32'(s_out_valid), 32'(q.size() > 0));
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then check.
  task automatic tick();
    exp_t e;
    bit   acc;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        e = ref_decode(opcode, funct3, funct7);
        q.push_back(e);
        if (e.ill) m_cnt++;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    in_valid = v;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_code"}, 32'(alu_control_signal), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_count"}, 32'(illegal_count), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vt[23];

  initial begin
    vt[0]  = '{7'h33, 3'd0, 7'h00, 4'h0, 1'b0};
    vt[1]  = '{7'h33, 3'd0, 7'h20, 4'h1, 1'b0};
    vt[2]  = '{7'h33, 3'd1, 7'h00, 4'h5, 1'b0};
    vt[3]  = '{7'h33, 3'd2, 7'h00, 4'h8, 1'b0};
    vt[4]  = '{7'h33, 3'd3, 7'h00, 4'hd, 1'b0};
    vt[5]  = '{7'h33, 3'd4, 7'h00, 4'h4, 1'b0};
    vt[6]  = '{7'h33, 3'd5, 7'h00, 4'h6, 1'b0};
    vt[7]  = '{7'h33, 3'd5, 7'h20, 4'h7, 1'b0};
    vt[8]  = '{7'h33, 3'd6, 7'h00, 4'h3, 1'b0};
    vt[9]  = '{7'h33, 3'd7, 7'h00, 4'h2, 1'b0};
    vt[10] = '{7'h33, 3'd7, 7'h20, 4'h0, 1'b1};
    vt[11] = '{7'h13, 3'd0, 7'h20, 4'h0, 1'b0};
    vt[12] = '{7'h13, 3'd1, 7'h20, 4'h0, 1'b1};
    vt[13] = '{7'h13, 3'd5, 7'h20, 4'h7, 1'b0};
    vt[14] = '{7'h13, 3'd5, 7'h01, 4'h0, 1'b1};
    vt[15] = '{7'h13, 3'd7, 7'h7f, 4'h2, 1'b0};
    vt[16] = '{7'h63, 3'd1, 7'h00, 4'h1, 1'b0};
    vt[17] = '{7'h63, 3'd3, 7'h00, 4'h0, 1'b1};
    vt[18] = '{7'h63, 3'd5, 7'h00, 4'h8, 1'b0};
    vt[19] = '{7'h63, 3'd7, 7'h00, 4'hd, 1'b0};
    vt[20] = '{7'h67, 3'd0, 7'h00, 4'h0, 1'b0};
    vt[21] = '{7'h17, 3'd3, 7'h55, 4'h0, 1'b0};
    vt[22] = '{7'h0f, 3'd0, 7'h00, 4'h0, 1'b1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; m_cnt = 0;
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_state("reset");

    // SUB through an empty stage: visible one cycle after acceptance
    drive(1'b1, 7'h33, 3'd0, 7'h20);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    chk("sub_code", 32'(alu_control_signal), 32'h1);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_illegal", 32'(illegal), 32'd0);
    tick();

    // Back-to-back table vectors at full throughput
    for (int i = 0; i < 23; i++) begin
      drive(1'b1, vt[i].op, vt[i].f3, vt[i].f7);
      tick();
      chk($sformatf("vec%0d_code", i), 32'(alu_control_signal), 32'(vt[i].code));
      chk($sformatf("vec%0d_ill", i), 32'(illegal), 32'(vt[i].ill));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
    end
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    tick();

    // Skid fill under backpressure, then ordered drain
    out_ready = 1'b0;
    drive(1'b1, 7'h33, 3'd0, 7'h00);
    tick();
    drive(1'b1, 7'h13, 3'd5, 7'h20);
    tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 7'h63, 3'd6, 7'h00);
    tick();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_code", 32'(alu_control_signal), 32'h0);
    out_ready = 1'b1;
    tick();
    chk("drain1_code", 32'(alu_control_signal), 32'h7);
    chk("drain1_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    chk("drain2_code", 32'(alu_control_signal), 32'hd);
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Illegal encodings from a clean reset, then saturation of the 2-bit counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 7'h73, 3'd0, 7'h00);
    tick();
    chk("ill_sys_code", 32'(alu_control_signal), 32'h0);
    chk("ill_sys_flag", 32'(illegal), 32'd1);
    drive(1'b1, 7'h33, 3'd0, 7'h01);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    chk("ill_r_flag", 32'(illegal), 32'd1);
    chk("ill_count2", 32'(illegal_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'h7f, 3'(i), 7'h00);
      tick();
    end
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    chk("sat_at_3", 32'(s_count), 32'd3);
    chk("count_5", 32'(illegal_count), 32'd5);
    tick();

    // Flush with both entries full and an illegal instruction presented
    out_ready = 1'b0;
    drive(1'b1, 7'h37, 3'd0, 7'h00);
    tick();
    tick();
    chk("pre_flush_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 7'h7b, 3'd0, 7'h00);
    tick();
    flush = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_count", 32'(illegal_count), 32'd5);
    out_ready = 1'b1;
    tick();
    chk("flush_no_ghost", 32'(out_valid), 32'd0);

    // Reset while an entry is held, then LUI after release
    drive(1'b1, 7'h33, 3'd4, 7'h00);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_state("midrst");
    rst = 1'b0;
    drive(1'b1, 7'h37, 3'd2, 7'h11);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00);
    chk("lui_valid", 32'(out_valid), 32'd1);
    chk("lui_code", 32'(alu_control_signal), 32'h0);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] ops [10];
      ops = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h00};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      opcode    = ops[$urandom_range(0, 9)];
      if (opcode == 7'h00) opcode = 7'($urandom);
      funct3    = 3'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    funct7 = 7'h00;
        2:       funct7 = 7'h20;
        default: funct7 = 7'($urandom);
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered ALU-control stage sitting directly upstream of the ALU-operation one-hot decoder. It accepts decoded RV32I instruction fields from ID through a valid/ready handshake and derives the 4-bit ALU control code. It presents that code to the one-hot decoder and EX from a two-entry skid buffer, so that `in_ready` is driven from a register. It also flags unsupported encodings and counts them.

## Interface
- `CNT_W`, default 8: width of the saturating illegal-instruction counter.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline kill from the branch/jump resolver.
- `in_valid`  in  1  ID presents an instruction.
- `in_ready`  out  1  stage can accept; registered, equals `~skid_valid`.
- `opcode`  in  7  instruction bits [6:0].
- `funct3`  in  3  instruction bits [14:12].
- `funct7`  in  7  instruction bits [31:25].
- `out_valid`  out  1  `alu_control_signal` is valid.
- `out_ready`  in  1  EX consumes this cycle.
- `alu_control_signal`  out  4  ALU code feeding the one-hot decoder.
- `illegal`  out  1  the held instruction is unsupported.
- `illegal_count`  out  CNT_W  number of illegal instructions accepted, saturating.

## Operation
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1101 SLTU.
  - No other code is ever emitted.
- R-type (0110011), by `funct3`:
  - 000: ADD, or SUB when `funct7`=0100000.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRL, or SRA when `funct7`=0100000.
  - `funct7` other than 0000000, or 0100000 on anything except 000/101, is illegal.
- I-type ALU (0010011):
  - Same `funct3` map as R-type, except 000 is always ADD.
  - 001 requires `funct7`=0000000.
  - 101 selects SRA on 0100000, SRL on 0000000, otherwise illegal.
- Branch (1100011):
  - 000/001 map to SUB.
  - 100/101 map to SLT.
  - 110/111 map to SLTU.
  - 010/011 are illegal.
- LOAD 0000011, STORE 0100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111: ADD.
- Any other opcode is illegal.
- An illegal instruction is emitted with code 0000 and `illegal`=1; it still flows through the stage.
- Skid buffer:
  - `main` register drives the outputs; `skid` holds one overflow entry.
  - Accept: `in_valid & in_ready & ~flush`.
  - Accepted while `main` is empty, or while `main` drains (`out_ready`) with `skid` empty: the instruction loads into `main`.
  - Accepted while `main` is full and not draining: it loads into `skid`.
  - `main` drains while `skid` is full: `skid` moves into `main`, and `in_ready` rises the next cycle.
  - Order is strictly FIFO.
- `illegal_count` increments on every accepted illegal instruction and holds at 2^CNT_W−1. It is not cleared by `flush`.

## Timing
- Reset values:
  - `out_valid`=0, `alu_control_signal`=0000, `illegal`=0.
  - `illegal_count`=0, skid empty, so `in_ready`=1 from the first cycle after reset.
- Reset asserted mid-operation drops both entries on the next edge.
- Latency: accept in cycle N → `out_valid`=1 with the code in cycle N+1 (empty stage).
- Throughput is 1 instruction per cycle while `out_ready`=1.
- Outputs stay stable while `out_valid & ~out_ready`.
- `in_ready` is not combinationally dependent on `out_ready`.
- `flush` has priority over every other event:
  - Next cycle: `out_valid`=0, skid empty, `in_ready`=1.
  - An instruction presented in the flush cycle is dropped and not counted.
- Simultaneous drain and accept with `skid` full cannot occur, because `in_ready`=0 in that state.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - Opcode localparams: OP_R, OP_I, OP_BR, OP_LD, OP_ST, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - The ten 4-bit ALU code constants, which are shared with the one-hot decoder.
  - A packed entry struct {code, illegal}.
- One combinational sub-module, `alu_ctrl_decode`, maps (opcode, funct3, funct7) → {code, illegal}.
- The top level holds the skid buffer and the counter.

## Test plan
- Reset, then R-type `funct3`=000 with `funct7`=0100000, `out_ready`=1:
  - Next cycle `alu_control_signal`=0001, `illegal`=0, `out_valid`=1.
- Hold `out_ready`=0 and send three back-to-back instructions (ADD, SRA via 0010011/101/0100000, SLTU branch 110):
  - First two are accepted; `in_ready`=0 on the third.
  - Release `out_ready`: codes 0000, 0111, 1101 are delivered in order with no loss.
- Opcode 1110011, and R-type with `funct7`=0000001:
  - Code 0000, `illegal`=1, `illegal_count`=2.
- With CNT_W=2, send 5 illegal instructions:
  - `illegal_count` saturates at 3.
- Both entries full, then assert `flush` together with `in_valid`:
  - Next cycle `out_valid`=0 and `in_ready`=1.
  - The flushed input never appears, and `illegal_count` is unchanged.
- Assert `rst` mid-stream with `out_valid`=1:
  - Next cycle all outputs are at reset values.
  - Deasserting `rst`, then sending a LUI, yields 0000 one cycle after acceptance.
